// File: rtl/fosfor_present_if.sv
// Nibble-wide host bus of the PRESENT-80 encryptor: function code, data nibble,
// registered read byte, and a debug view of the engine state.
interface fosfor_present_if;
  logic [1:0] Address_b;
  logic [3:0] DataIn_b;
  logic [7:0] DataOut_b;
  logic       dbg_busy;

  modport master (output Address_b, output DataIn_b, input DataOut_b, input dbg_busy);
  modport slave  (input Address_b, input DataIn_b, output DataOut_b, output dbg_busy);
endinterface

// File: rtl/fosfor_present.sv
// PRESENT-80 encryptor behind an 8-bit register map that is reached through a nibble bus.
// One round per clock: 31 rounds followed by a final key whitening.
module fosfor_present (
  input  logic             Clk_k,
  input  logic             Reset_rn,
  fosfor_present_if.slave  bus
);

  localparam logic [1:0] A_LOW  = 2'd1;
  localparam logic [1:0] A_HIGH = 2'd2;
  localparam logic [1:0] A_CMD  = 2'd3;
  localparam logic [3:0] CMD_LATCH = 4'd1;
  localparam logic [3:0] CMD_WRITE = 4'd2;
  localparam logic [3:0] CMD_START = 4'd3;

  typedef enum logic {S_IDLE, S_RUN} fsm_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  fsm_t        r_fsm;
  fsm_t        w_fsm_next;
  logic [7:0]  r_data;
  logic [7:0]  r_addr;
  logic [7:0]  r_scratch;
  logic [63:0] r_state;
  logic [79:0] r_key;
  logic [79:0] r_wkey;
  logic [5:0]  r_round;
  logic        r_out_data;
  logic [7:0]  r_dout;

  logic        w_busy;
  logic        w_do_round;
  logic        w_do_final;
  logic        w_cmd_latch;
  logic        w_cmd_write;
  logic        w_start;
  logic        w_addr_state;
  logic        w_addr_key;
  logic [7:0]  w_rd;

  assign w_cmd_latch  = (bus.Address_b == A_CMD) && (bus.DataIn_b == CMD_LATCH);
  assign w_cmd_write  = (bus.Address_b == A_CMD) && (bus.DataIn_b == CMD_WRITE);
  assign w_start      = (bus.Address_b == A_CMD) && (bus.DataIn_b == CMD_START) && !w_busy;
  assign w_addr_state = (r_addr[7:3] == 5'd0);
  assign w_addr_key   = (r_addr[7:4] == 4'h1) && (r_addr[3:0] <= 4'd9);

  always_ff @(posedge Clk_k) begin
    if (!Reset_rn) r_fsm <= S_IDLE;
    else           r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:  if (w_start) w_fsm_next = S_RUN;
      default: if (r_round == 6'd32) w_fsm_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_fsm == S_RUN);
    w_do_round = w_busy && (r_round <= 6'd31);
    w_do_final = w_busy && (r_round == 6'd32);
  end

  // Key bytes are write-only, so they never appear on the read mux.
  always_comb begin
    w_rd = 8'h00;
    if (w_addr_state)           w_rd = r_state[{r_addr[2:0], 3'b000} +: 8];
    else if (r_addr == 8'h08)   w_rd = r_scratch;
  end

  always_ff @(posedge Clk_k) begin
    if (!Reset_rn) begin
      r_data     <= '0;
      r_addr     <= '0;
      r_scratch  <= '0;
      r_state    <= '0;
      r_key      <= '0;
      r_wkey     <= '0;
      r_round    <= '0;
      r_out_data <= 1'b0;
      r_dout     <= '0;
    end else begin
      if (bus.Address_b == A_LOW)  r_data[3:0] <= bus.DataIn_b;
      if (bus.Address_b == A_HIGH) r_data[7:4] <= bus.DataIn_b;
      if (w_cmd_latch) begin
        r_addr     <= r_data;
        r_out_data <= 1'b1;
      end
      if (w_cmd_write) begin
        r_out_data <= 1'b0;
        if (r_addr == 8'h08)            r_scratch <= r_data;
        else if (!w_busy && w_addr_state) r_state[{r_addr[2:0], 3'b000} +: 8] <= r_data;
        else if (!w_busy && w_addr_key)   r_key[{r_addr[3:0], 3'b000} +: 8] <= r_data;
      end
      if (bus.Address_b == A_CMD && bus.DataIn_b == CMD_START) r_out_data <= 1'b0;
      // The stored key stays intact so a later START re-encrypts with the same key.
      if (w_start) begin
        r_wkey  <= r_key;
        r_round <= 6'd1;
      end else if (w_do_round) begin
        r_state <= p_layer(s_layer(r_state ^ r_wkey[79:16]));
        r_wkey  <= key_update(r_wkey, r_round[4:0]);
        r_round <= r_round + 6'd1;
      end else if (w_do_final) begin
        r_state <= r_state ^ r_wkey[79:16];
        r_round <= 6'd0;
      end
      r_dout <= r_out_data ? w_rd : {7'b0, ~w_busy};
    end
  end

  assign bus.DataOut_b = r_dout;
  assign bus.dbg_busy  = w_busy;

endmodule

// File: tb/tb_fosfor_present.sv
// Directed bench for fosfor_present: bus register access, the two reference PRESENT-80
// vectors, busy-time command guards and reset during an encryption.
module tb_fosfor_present;

  localparam logic [1:0] A_IDLE = 2'd0;
  localparam logic [1:0] A_LOW  = 2'd1;
  localparam logic [1:0] A_HIGH = 2'd2;
  localparam logic [1:0] A_CMD  = 2'd3;
  localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
  localparam logic [63:0] CT_ONES = 64'h3333DCD3213210D2;
  // START edge is 0, busy clears on edge 32, registered status shows ready on edge 33.
  localparam int DONE_EDGE = 33;

  logic Clk_k = 1'b0;
  logic Reset_rn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_cnt = 0;
  int   t0;
  int   took;
  logic [7:0]  b;
  logic [63:0] s;

  fosfor_present_if bus ();

  fosfor_present dut (
    .Clk_k    (Clk_k),
    .Reset_rn (Reset_rn),
    .bus      (bus)
  );

  always #5 Clk_k = ~Clk_k;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [3:0] d);
    bus.Address_b = a;
    bus.DataIn_b  = d;
    @(posedge Clk_k);
    #1;
    edge_cnt++;
  endtask

  task automatic latch_addr(input logic [7:0] addr);
    step(A_LOW, addr[3:0]);
    step(A_HIGH, addr[7:4]);
    step(A_CMD, 4'd1);
  endtask

  task automatic wr_byte(input logic [7:0] addr, input logic [7:0] val);
    latch_addr(addr);
    step(A_LOW, val[3:0]);
    step(A_HIGH, val[7:4]);
    step(A_CMD, 4'd2);
  endtask

  task automatic rd_byte(input logic [7:0] addr, output logic [7:0] val);
    latch_addr(addr);
    step(A_IDLE, 4'd0);
    val = bus.DataOut_b;
  endtask

  task automatic load_key(input logic [79:0] k);
    for (int i = 0; i < 10; i++) wr_byte(8'(16 + i), k[8*i +: 8]);
  endtask

  task automatic load_pt(input logic [63:0] p);
    for (int i = 0; i < 8; i++) wr_byte(8'(i), p[8*i +: 8]);
  endtask

  task automatic rd_state(output logic [63:0] v);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) begin
      rd_byte(8'(i), x);
      v[8*i +: 8] = x;
    end
  endtask

  task automatic start(output int t_start);
    step(A_CMD, 4'd3);
    t_start = edge_cnt;
  endtask

  task automatic wait_ready(input int t_start, output int t_done);
    t_done = -1;
    for (int k = 0; k < 60; k++) begin
      step(A_IDLE, 4'd0);
      if (bus.DataOut_b[0]) begin
        t_done = edge_cnt - t_start;
        break;
      end
    end
  endtask

  initial begin
    bus.Address_b = A_IDLE;
    bus.DataIn_b  = 4'd0;
    Reset_rn = 1'b0;
    step(A_IDLE, 4'd0);
    step(A_IDLE, 4'd0);
    check("rst_dout", bus.DataOut_b, 8'h00);
    Reset_rn = 1'b1;
    step(A_IDLE, 4'd0);
    check("post_rst_status1", bus.DataOut_b, 8'h01);
    step(A_IDLE, 4'd0);
    check("post_rst_status2", bus.DataOut_b, 8'h01);

    wr_byte(8'h08, 8'hA5);
    rd_byte(8'h08, b);
    check("scratch_rw", b, 8'hA5);
    wr_byte(8'h20, 8'h5A);
    rd_byte(8'h20, b);
    check("unmapped_rd", b, 8'h00);

    load_key(80'h0);
    load_pt(64'h0);
    start(t0);
    step(A_IDLE, 4'd0);
    check("zero_busy_status", bus.DataOut_b, 8'h00);
    wait_ready(t0, took);
    check("zero_done_edge", 64'(took), 64'(DONE_EDGE));
    rd_state(s);
    check("zero_ct", s, CT_ZERO);

    load_key({80{1'b1}});
    rd_byte(8'h10, b);
    check("key_rd_zero", b, 8'h00);
    rd_byte(8'h19, b);
    check("key_hi_rd_zero", b, 8'h00);
    load_pt({64{1'b1}});
    rd_byte(8'h03, b);
    check("pt_readback", b, 8'hFF);
    start(t0);
    wait_ready(t0, took);
    check("ones_done_edge", 64'(took), 64'(DONE_EDGE));
    rd_state(s);
    check("ones_ct", s, CT_ONES);

    load_key(80'h0);
    load_pt(64'h0);
    start(t0);
    step(A_IDLE, 4'd0);
    step(A_IDLE, 4'd0);
    step(A_CMD, 4'd3);
    wr_byte(8'h00, 8'h77);
    wait_ready(t0, took);
    check("guard_done_edge", 64'(took), 64'(DONE_EDGE));
    rd_state(s);
    check("guard_ct", s, CT_ZERO);

    wr_byte(8'h08, 8'h3C);
    load_key({80{1'b1}});
    load_pt(64'h0123456789ABCDEF);
    start(t0);
    for (int k = 0; k < 5; k++) step(A_IDLE, 4'd0);
    Reset_rn = 1'b0;
    step(A_IDLE, 4'd0);
    Reset_rn = 1'b1;
    step(A_IDLE, 4'd0);
    check("midrun_rst_status", bus.DataOut_b, 8'h01);
    rd_byte(8'h08, b);
    check("midrun_rst_scratch", b, 8'h00);
    rd_state(s);
    check("midrun_rst_state", s, 64'h0);
    // Cleared key and cleared state must reproduce the all-zero reference vector.
    start(t0);
    wait_ready(t0, took);
    check("after_rst_done_edge", 64'(took), 64'(DONE_EDGE));
    rd_state(s);
    check("after_rst_ct", s, CT_ZERO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
